// File: rtl/ft232h_pkg.sv
// Shared bus width, FSM state encoding and strobe bundle for the FT232H
// synchronous-FIFO bridge.
package ft232h_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RX_OE    = 2'd1,
        RX_READ  = 2'd2,
        TX_WRITE = 2'd3
    } state_e;

    // Active-low FT232H strobes, registered together.
    typedef struct packed {
        logic rd_n;
        logic wr_n;
        logic oe_n;
    } bus_ctrl_t;

    localparam bus_ctrl_t BUS_CTRL_IDLE = '{rd_n: 1'b1, wr_n: 1'b1, oe_n: 1'b1};

endpackage

// File: rtl/ft232h_fifo.sv
// Show-ahead synchronous FIFO: head_o always presents the oldest entry,
// level_o reports occupancy 0..DEPTH. DEPTH must be a power of two.
module ft232h_fifo
    import ft232h_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  byte_t                   push_data_i,
    input  logic                    pop_i,
    output byte_t                   head_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // NOTE: storage is deliberately not reset; level_q gates every read, so
    // stale contents are never observed and the array maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            // NOTE: non-blocking assignments let every flop see pre-edge values.
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ft232h_sync_fifo.sv
// FT232H synchronous-FIFO bridge: buffered user TX/RX streams to the 60 MHz bus.
// Define FT232H_PATTERN_EN to replace the user TX stream with a byte counter.
module ft232h_sync_fifo
    import ft232h_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       rxf_n,
    input  logic                       txe_n,
    output logic                       rd_n,
    output logic                       wr_n,
    output logic                       oe_n,
    output logic                       siwu_n,
    inout  wire  [DATA_W-1:0]          data,
    input  logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [DATA_W-1:0]          rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(TX_DEPTH):0]  tx_level,
    output logic [$clog2(RX_DEPTH):0]  rx_level
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_ONE       = (TAW+1)'(1);
    localparam logic [RAW:0] RX_ONE       = (RAW+1)'(1);
    localparam logic [RAW:0] RX_ENTER_MAX = (RAW+1)'(RX_DEPTH - 2);
    localparam logic [RAW:0] RX_STOP      = (RAW+1)'(RX_DEPTH - 1);

    state_e       state_q;
    state_e       state_d;
    bus_ctrl_t    ctrl_q;
    bus_ctrl_t    ctrl_d;

    logic         tx_push;
    logic         tx_pop;
    logic         tx_empty;
    logic         tx_avail;
    logic         tx_last;
    byte_t        tx_head;
    byte_t        tx_word;
    logic         rx_push;
    logic         rx_pop;
    logic         rx_empty;
    logic [RAW:0] rx_level_next;

    // Bus handshakes are qualified by the registered strobes, i.e. what the
    // FT232H actually sees at the edge.
    assign rx_push  = ~ctrl_q.rd_n & ~rxf_n;
    assign tx_pop   = ~ctrl_q.wr_n & ~txe_n;
    assign rx_valid = ~rx_empty;
    assign rx_pop   = rx_valid & rx_ready;

    assign rd_n   = ctrl_q.rd_n;
    assign wr_n   = ctrl_q.wr_n;
    assign oe_n   = ctrl_q.oe_n;
    assign siwu_n = 1'b1;
    assign data   = ~ctrl_q.wr_n ? tx_word : {DATA_W{1'bz}};

`ifdef FT232H_PATTERN_EN
    byte_t pattern_q;

    assign tx_ready = 1'b0;
    assign tx_push  = 1'b0;
    assign tx_word  = pattern_q;
    assign tx_avail = 1'b1;
    assign tx_last  = 1'b0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
        end else if (tx_pop) begin
            pattern_q <= pattern_q + 8'd1;
        end
    end
`else
    assign tx_ready = (tx_level < (TAW+1)'(TX_DEPTH));
    assign tx_push  = tx_valid & tx_ready;
    assign tx_word  = tx_head;
    assign tx_avail = ~tx_empty;
    assign tx_last  = tx_pop & ~tx_push & (tx_level == TX_ONE);
`endif

    ft232h_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock       (clock),
        .rst_n       (rst_n),
        .push_i      (tx_push),
        .push_data_i (tx_data),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .level_o     (tx_level),
        .empty_o     (tx_empty)
    );

    ft232h_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock       (clock),
        .rst_n       (rst_n),
        .push_i      (rx_push),
        .push_data_i (data),
        .pop_i       (rx_pop),
        .head_o      (rx_data),
        .level_o     (rx_level),
        .empty_o     (rx_empty)
    );

    always_comb begin
        rx_level_next = rx_level;
        if (rx_push && !rx_pop) begin
            rx_level_next = rx_level + RX_ONE;
        end else if (!rx_push && rx_pop) begin
            rx_level_next = rx_level - RX_ONE;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= BUS_CTRL_IDLE;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // NOTE: defaulting state_d first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rxf_n && (rx_level <= RX_ENTER_MAX)) begin
                    state_d = RX_OE;
                end else if (!txe_n && tx_avail) begin
                    state_d = TX_WRITE;
                end
            end
            RX_OE:    state_d = RX_READ;
            RX_READ:  if (rxf_n || (rx_level_next >= RX_STOP)) state_d = IDLE;
            TX_WRITE: if (txe_n || tx_last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave a flop cleanly.
    always_comb begin
        ctrl_d = BUS_CTRL_IDLE;
        case (state_d)
            RX_OE: begin
                ctrl_d.oe_n = 1'b0;
            end
            RX_READ: begin
                ctrl_d.oe_n = 1'b0;
                ctrl_d.rd_n = 1'b0;
            end
            TX_WRITE: begin
                ctrl_d.wr_n = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ft232h_sync_fifo.sv
// Scoreboard bench for ft232h_sync_fifo with a small FT232H host model;
// both buffers are sized 4 so full/stop boundaries and pointer wrap are reached.
module tb_ft232h_sync_fifo;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic       clock;
    logic       rst_n;
    logic       rxf_n;
    logic       txe_n;
    logic       rd_n;
    logic       wr_n;
    logic       oe_n;
    logic       siwu_n;
    wire  [7:0] bus;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] tx_level;
    logic [2:0] rx_level;

    logic [7:0] host_byte;
    logic       host_hold;
    logic       host_take;
    logic [7:0] host_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int tx_acc_cnt = 0;
    int wr_low_cnt = 0;
    int rx_max     = 0;

    ft232h_sync_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .oe_n     (oe_n),
        .siwu_n   (siwu_n),
        .data     (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_level (tx_level),
        .rx_level (rx_level)
    );

    // The FT232H drives the bus whenever output enable is asserted.
    assign bus = (!oe_n) ? host_byte : 8'hzz;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_refresh();
        if (host_q.size() != 0) host_byte = host_q[0];
        rxf_n = host_hold || (host_q.size() == 0);
    endtask

    task automatic host_send(input logic [7:0] b);
        host_q.push_back(b);
        exp_rx_q.push_back(b);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_tx_ready_timeout", n < 100, 1);
        exp_tx_q.push_back(b);
        tick();
        tx_valid = 1'b0;
    endtask

    // Host model: a byte is consumed on an edge where rd_n and rxf_n are both low.
    initial begin
        host_byte = 8'h00;
        host_take = 1'b0;
        forever begin
            @(negedge clock);
            host_take = !rd_n && !rxf_n;
            @(posedge clock);
            #1;
            if (host_take && host_q.size() != 0) void'(host_q.pop_front());
            host_refresh();
        end
    end

    // Monitor: everything is sampled mid-cycle, describing the coming edge.
    initial begin
        logic       prev_oe_n = 1'b1;
        logic       prev_wr_n = 1'b1;
        logic       prev_rd_n = 1'b1;
        int         oe_run    = 0;
        logic [7:0] exp;
        forever begin
            @(negedge clock);
            if (rst_n) begin
                if (!wr_n && !txe_n) begin
                    if (exp_tx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: bus carried 0x%0h with nothing expected", bus);
                    end else begin
                        exp = exp_tx_q.pop_front();
                        check("tx_bus_byte", bus, exp);
                    end
                    tx_acc_cnt++;
                end
                if (!wr_n) wr_low_cnt++;
                if (!wr_n && prev_wr_n) check("tx_idle_gap_before_write", prev_oe_n, 1);
                if (!oe_n) begin
                    check("no_write_while_oe", wr_n, 1);
                    check("bus_owned_by_host", bus, host_byte);
                end
                if (!rd_n && prev_rd_n) check("single_rx_oe_cycle", oe_run, 1);
                oe_run = (!oe_n && rd_n) ? oe_run + 1 : 0;
                if (rx_valid && rx_ready) begin
                    if (exp_rx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_unexpected: rx_data 0x%0h with nothing expected", rx_data);
                    end else begin
                        exp = exp_rx_q.pop_front();
                        check("rx_stream_byte", rx_data, exp);
                    end
                end
                if (int'(rx_level) > rx_max) rx_max = int'(rx_level);
            end
            prev_oe_n = oe_n;
            prev_wr_n = wr_n;
            prev_rd_n = rd_n;
        end
    end

    initial begin
        int n;
        int acc0;
        int wl0;
        rst_n     = 1'b1;
        txe_n     = 1'b1;
        rxf_n     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b1;
        host_hold = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_oe_n", oe_n, 1);
        check("rst_siwu_n", siwu_n, 1);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        repeat (2) @(posedge clock);
        @(negedge clock) rst_n = 1'b1;
        tick();
        tick();

        // Three-byte TX burst with the host always ready.
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        check("tx_level_three", tx_level, 3);
        check("tx_ready_partial", tx_ready, 1);
        acc0  = tx_acc_cnt;
        wl0   = wr_low_cnt;
        txe_n = 1'b0;
        n = 0;
        while (!(tx_level == 0 && wr_n) && n < 50) begin tick(); n++; end
        check("tx_burst_timeout", n < 50, 1);
        check("tx_burst_accepts", tx_acc_cnt - acc0, 3);
        check("tx_burst_wr_low_edges", wr_low_cnt - wl0, 3);
        check("tx_burst_level_zero", tx_level, 0);
        txe_n = 1'b1;
        tick();

        // Fill TX to capacity, then stall the host while 0x22 is on the bus.
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        push_tx(8'h44);
        check("tx_level_full", tx_level, 4);
        check("tx_ready_full", tx_ready, 0);
        acc0  = tx_acc_cnt;
        txe_n = 1'b0;
        n = 0;
        while (!(!wr_n && bus == 8'h22) && n < 50) begin tick(); n++; end
        check("tx_saw_22_timeout", n < 50, 1);
        txe_n = 1'b1;
        tick();
        tick();
        check("tx_stall_wr_n", wr_n, 1);
        check("tx_stall_level", tx_level, 3);
        check("tx_ready_after_pop", tx_ready, 1);
        txe_n = 1'b0;
        n = 0;
        while (!(tx_level == 0 && wr_n) && n < 50) begin tick(); n++; end
        check("tx_resume_timeout", n < 50, 1);
        check("tx_resume_accepts", tx_acc_cnt - acc0, 4);
        txe_n = 1'b1;
        tick();

        // Host delivers 0xA0..0xA4 into a draining consumer.
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) host_send(8'hA0 + 8'(i));
        n = 0;
        while (!(exp_rx_q.size() == 0 && rd_n) && n < 100) begin tick(); n++; end
        check("rx_stream_timeout", n < 100, 1);
        check("rx_stream_level_zero", rx_level, 0);

        // Stalled consumer: the read burst must stop at RX_DEPTH-1.
        rx_ready = 1'b0;
        rx_max   = 0;
        for (int i = 0; i < 8; i++) host_send(8'hB0 + 8'(i));
        n = 0;
        while (rd_n && n < 50) begin tick(); n++; end
        check("rx_full_start_timeout", n < 50, 1);
        n = 0;
        while (!rd_n && n < 50) begin tick(); n++; end
        check("rx_full_stop_timeout", n < 50, 1);
        check("rx_stop_level", rx_level, 3);
        repeat (5) tick();
        check("rx_hold_rd_n", rd_n, 1);
        check("rx_hold_oe_n", oe_n, 1);
        check("rx_hold_level", rx_level, 3);
        check("rx_no_overflow", rx_max, 3);
        check("rx_head_first", rx_data, 8'hB0);
        rx_ready = 1'b1;
        n = 0;
        while (!(exp_rx_q.size() == 0 && host_q.size() == 0 && rd_n) && n < 200) begin tick(); n++; end
        check("rx_drain_timeout", n < 200, 1);
        check("rx_drain_level", rx_level, 0);

        // RX and TX requested together: RX wins, then TX after an idle cycle.
        host_hold = 1'b1;
        host_refresh();
        push_tx(8'h55);
        push_tx(8'h66);
        host_send(8'hC0);
        host_send(8'hC1);
        host_send(8'hC2);
        tick();
        host_hold = 1'b0;
        host_refresh();
        txe_n = 1'b0;
        tick();
        check("prio_rx_oe", oe_n, 0);
        check("prio_tx_waits", wr_n, 1);
        check("prio_tx_pending", tx_level, 2);
        n = 0;
        while (!(exp_rx_q.size() == 0 && tx_level == 0 && wr_n) && n < 100) begin tick(); n++; end
        check("prio_done_timeout", n < 100, 1);
        check("prio_exp_tx_empty", exp_tx_q.size(), 0);
        txe_n = 1'b1;
        tick();

        // Reset asserted in the middle of an RX burst.
        rx_ready  = 1'b0;
        host_hold = 1'b1;
        host_refresh();
        for (int i = 0; i < 4; i++) host_send(8'hD0 + 8'(i));
        tick();
        host_hold = 1'b0;
        host_refresh();
        n = 0;
        while (!(!rd_n && rx_level >= 1) && n < 50) begin tick(); n++; end
        check("rst_mid_burst_timeout", n < 50, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rd_n", rd_n, 1);
        check("rst_mid_oe_n", oe_n, 1);
        check("rst_mid_wr_n", wr_n, 1);
        check("rst_mid_rx_level", rx_level, 0);
        check("rst_mid_tx_level", tx_level, 0);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_tx_ready", tx_ready, 1);
        host_q.delete();
        exp_rx_q.delete();
        exp_tx_q.delete();
        host_hold = 1'b1;
        host_refresh();
        rx_ready = 1'b1;
        @(negedge clock) rst_n = 1'b1;
        tick();
        tick();

        // Traffic resumes cleanly after the abort.
        host_hold = 1'b0;
        host_send(8'hE0);
        host_send(8'hE1);
        txe_n = 1'b0;
        push_tx(8'h77);
        n = 0;
        while (!(exp_rx_q.size() == 0 && exp_tx_q.size() == 0 && tx_level == 0 && rd_n && wr_n) && n < 100) begin
            tick();
            n++;
        end
        check("post_reset_timeout", n < 100, 1);
        check("post_reset_rx_level", rx_level, 0);
        check("post_reset_tx_level", tx_level, 0);
        txe_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
